// File: rtl/tic_tac_toe_btn_conditioner.sv
// tic_tac_toe_btn_conditioner
// Turns the five raw game buttons (L, R, U, D, C) into clean, registered
// levels and single-cycle move/select pulses, with auto-repeat on held
// direction buttons and a fixed-priority arbiter so at most one pulse
// reaches the controller per cycle.
module tic_tac_toe_btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 10000000,
    parameter logic [4:0]  REPEAT_MASK     = 5'b01111
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [4:0] PB,
    output logic [4:0] DPB,
    output logic [4:0] Pulse,
    output logic       PulseAny,
    output logic       Dropped
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_FULL = DW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] RCNT_ONE   = RW'(1);
    localparam logic [RW-1:0] RCNT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RCNT_RATE  = RW'(REPEAT_RATE);

    // A zero delay switches auto-repeat off for every button at once.
    localparam logic [4:0] REPEAT_EN = (REPEAT_DELAY != 0) ? REPEAT_MASK : 5'b00000;

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } btn_state_e;

    logic [4:0]    sync1_q;
    logic [4:0]    sync2_q;
    logic [4:0]    s;

    btn_state_e    state_q [5];
    btn_state_e    state_d [5];
    logic [DW-1:0] dcnt_q  [5];
    logic [DW-1:0] dcnt_d  [5];
    logic [RW-1:0] rcnt_q  [5];
    logic [RW-1:0] rcnt_d  [5];

    logic [4:0]    cand;
    logic [4:0]    win;
    logic [4:0]    dpb_q;
    logic [4:0]    dpb_d;
    logic [4:0]    pulse_q;
    logic [4:0]    pulse_d;
    logic          pulseAny_q;
    logic          pulseAny_d;
    logic          dropped_q;
    logic          dropped_d;

    assign s = sync2_q;

    // One repeat-counter step: fire-and-reload at 1, otherwise count down,
    // and never move below zero.
    function automatic logic [RW-1:0] repeatStep(input logic [RW-1:0] r);
        if (r == RCNT_ONE) begin
            return RCNT_RATE;
        end else if (r != '0) begin
            return r - RCNT_ONE;
        end else begin
            return r;
        end
    endfunction

    // Two-flop synchroniser bringing the asynchronous buttons into the clock domain.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= PB;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered-output flops for all five buttons.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 5; k++) begin
                state_q[k] <= IDLE;
                dcnt_q[k]  <= '0;
                rcnt_q[k]  <= '0;
            end
            dpb_q      <= '0;
            pulse_q    <= '0;
            pulseAny_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                state_q[k] <= state_d[k];
                dcnt_q[k]  <= dcnt_d[k];
                rcnt_q[k]  <= rcnt_d[k];
            end
            dpb_q      <= dpb_d;
            pulse_q    <= pulse_d;
            pulseAny_q <= pulseAny_d;
            dropped_q  <= dropped_d;
        end
    end

    // Per-button debounce FSM and counter datapath. A glitch back to high
    // during release debounce resumes the repeat countdown on that same
    // edge, so the repeat schedule slips by exactly the low time.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            state_d[k] = state_q[k];
            dcnt_d[k]  = dcnt_q[k];
            rcnt_d[k]  = rcnt_q[k];
            case (state_q[k])
                IDLE: begin
                    if (s[k]) begin
                        state_d[k] = ARM_PRESS;
                        dcnt_d[k]  = DCNT_ONE;
                    end else begin
                        dcnt_d[k]  = '0;
                    end
                end
                ARM_PRESS: begin
                    if (!s[k]) begin
                        state_d[k] = IDLE;
                        dcnt_d[k]  = '0;
                    end else if (dcnt_q[k] >= DCNT_LAST) begin
                        state_d[k] = PRESSED;
                        dcnt_d[k]  = DCNT_FULL;
                        rcnt_d[k]  = RCNT_DELAY;
                    end else begin
                        dcnt_d[k]  = dcnt_q[k] + DCNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s[k]) begin
                        state_d[k] = ARM_RELEASE;
                        dcnt_d[k]  = DCNT_ONE;
                    end else if (REPEAT_EN[k]) begin
                        rcnt_d[k]  = repeatStep(rcnt_q[k]);
                    end
                end
                ARM_RELEASE: begin
                    if (s[k]) begin
                        state_d[k] = PRESSED;
                        dcnt_d[k]  = DCNT_FULL;
                        if (REPEAT_EN[k]) begin
                            rcnt_d[k] = repeatStep(rcnt_q[k]);
                        end
                    end else if (dcnt_q[k] >= DCNT_LAST) begin
                        state_d[k] = IDLE;
                        dcnt_d[k]  = '0;
                    end else begin
                        dcnt_d[k]  = dcnt_q[k] + DCNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                    dcnt_d[k]  = '0;
                end
            endcase
        end
    end

    // Pulse candidates, debounced levels and the C > U > D > L > R arbiter;
    // losing candidates are discarded and flagged through Dropped.
    always_comb begin
        cand  = '0;
        dpb_d = '0;
        for (int k = 0; k < 5; k++) begin
            case (state_q[k])
                ARM_PRESS:            cand[k] = s[k] && (dcnt_q[k] >= DCNT_LAST);
                PRESSED, ARM_RELEASE: cand[k] = s[k] && REPEAT_EN[k] && (rcnt_q[k] == RCNT_ONE);
                default:              cand[k] = 1'b0;
            endcase
            dpb_d[k] = (state_d[k] == PRESSED) || (state_d[k] == ARM_RELEASE);
        end

        win = 5'b00000;
        if (cand[4]) begin
            win = 5'b10000;
        end else if (cand[2]) begin
            win = 5'b00100;
        end else if (cand[3]) begin
            win = 5'b01000;
        end else if (cand[0]) begin
            win = 5'b00001;
        end else if (cand[1]) begin
            win = 5'b00010;
        end

        pulse_d    = win;
        pulseAny_d = |cand;
        dropped_d  = |(cand & ~win);
    end

    assign DPB      = dpb_q;
    assign Pulse    = pulse_q;
    assign PulseAny = pulseAny_q;
    assign Dropped  = dropped_q;

endmodule

// File: tb/tb_tic_tac_toe_btn_conditioner.sv
// tb_tic_tac_toe_btn_conditioner
// Scoreboard bench for the button conditioner: each scenario pushes the
// pulses it expects (edge number, value, dropped flag) and a monitor pops
// and compares them as the DUT emits pulses.
module tb_tic_tac_toe_btn_conditioner;

    logic       Clk;
    logic       reset_n;
    logic [4:0] PB;
    logic [4:0] DPB;
    logic [4:0] Pulse;
    logic       PulseAny;
    logic       Dropped;

    int unsigned cyc;
    int          checks;
    int          failures;

    typedef struct {
        int unsigned at;
        logic [4:0]  pulse;
        logic        drop;
    } expEntry_t;

    expEntry_t expQ [$];

    tic_tac_toe_btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_MASK     (5'b01111)
    ) dut (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .PB       (PB),
        .DPB      (DPB),
        .Pulse    (Pulse),
        .PulseAny (PulseAny),
        .Dropped  (Dropped)
    );

    // 10-time-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Rising-edge counter used to timestamp expected pulses.
    initial begin
        cyc = 0;
        forever begin
            @(posedge Clk);
            cyc = cyc + 1;
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, required completion before it");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void pushExp(input int unsigned at, input logic [4:0] p, input logic d);
        expEntry_t e;
        e.at    = at;
        e.pulse = p;
        e.drop  = d;
        expQ.push_back(e);
    endfunction

    task automatic waitToEdge(input int unsigned e);
        while (cyc < e) @(negedge Clk);
    endtask

    // Pops the scoreboard whenever the DUT pulses, and flags pulses that never came.
    task automatic monitorLoop();
        expEntry_t e;
        forever begin
            @(negedge Clk);
            if (Pulse !== 5'b00000 || Dropped !== 1'b0) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pulse: edge %0d Pulse=%b Dropped=%b, required Pulse=00000 Dropped=0",
                             cyc, Pulse, Dropped);
                end else begin
                    e = expQ.pop_front();
                    if (cyc != e.at || Pulse !== e.pulse || Dropped !== e.drop || PulseAny !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL pulse_match: edge %0d Pulse=%b Dropped=%b PulseAny=%b, required edge %0d Pulse=%b Dropped=%b PulseAny=1",
                                 cyc, Pulse, Dropped, PulseAny, e.at, e.pulse, e.drop);
                    end
                end
            end else begin
                checks++;
                if (PulseAny !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL pulseany_idle: edge %0d PulseAny=%b, required 0", cyc, PulseAny);
                end
                if (expQ.size() != 0 && expQ[0].at <= cyc) begin
                    e = expQ.pop_front();
                    checks++;
                    failures++;
                    $display("[TB] FAIL missed_pulse: edge %0d Pulse=%b, required Pulse=%b at edge %0d",
                             cyc, Pulse, e.pulse, e.at);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        PB      = 5'b00000;
        repeat (3) @(negedge Clk);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_dpb: DPB=%b, required 00000", DPB);
        end
        checks++;
        if (Pulse !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_pulse: Pulse=%b, required 00000", Pulse);
        end
        checks++;
        if (PulseAny !== 1'b0 || Dropped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: PulseAny=%b Dropped=%b, required 0 0", PulseAny, Dropped);
        end
        reset_n = 1'b1;
        waitToEdge(cyc + 3);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_idle_dpb: DPB=%b, required 00000", DPB);
        end
    endtask

    task automatic test_clean_press();
        int unsigned t0;
        int unsigned r0;
        t0 = cyc + 1;
        PB = 5'b10000;
        pushExp(t0 + 5, 5'b10000, 1'b0);
        waitToEdge(t0 + 4);
        checks++;
        if (DPB[4] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clean_dpb_early: DPB[4]=%b, required 0", DPB[4]);
        end
        waitToEdge(t0 + 5);
        checks++;
        if (DPB !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL clean_dpb_rise: DPB=%b, required 10000", DPB);
        end
        waitToEdge(t0 + 19);
        PB = 5'b00000;
        r0 = t0 + 20;
        waitToEdge(r0 + 4);
        checks++;
        if (DPB[4] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_dpb_hold: DPB[4]=%b, required 1", DPB[4]);
        end
        waitToEdge(r0 + 5);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL clean_dpb_fall: DPB=%b, required 00000", DPB);
        end
        waitToEdge(r0 + 8);
    endtask

    task automatic test_bounce();
        bit [0:6] seq;
        seq = 7'b1101110;
        for (int i = 0; i < 7; i++) begin
            PB[0] = seq[i];
            @(negedge Clk);
            checks++;
            if (DPB[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bounce_dpb step %0d: DPB[0]=%b, required 0", i, DPB[0]);
            end
        end
        PB = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            checks++;
            if (DPB[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bounce_settle step %0d: DPB[0]=%b, required 0", i, DPB[0]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int unsigned t0;
        int unsigned r0;
        t0 = cyc + 1;
        PB = 5'b00100;
        pushExp(t0 + 5, 5'b00100, 1'b0);
        for (int n = 0; n < 6; n++) begin
            pushExp(t0 + 15 + 3 * n, 5'b00100, 1'b0);
        end
        waitToEdge(t0 + 15);
        checks++;
        if (DPB !== 5'b00100) begin
            failures++;
            $display("[TB] FAIL repeat_dpb: DPB=%b, required 00100", DPB);
        end
        waitToEdge(t0 + 29);
        PB = 5'b00000;
        r0 = t0 + 30;
        waitToEdge(r0 + 5);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL repeat_dpb_fall: DPB=%b, required 00000", DPB);
        end
        waitToEdge(r0 + 10);
    endtask

    task automatic test_simultaneous();
        int unsigned t0;
        int unsigned r0;
        t0 = cyc + 1;
        PB = 5'b00011;
        pushExp(t0 + 5, 5'b00001, 1'b1);
        waitToEdge(t0 + 5);
        checks++;
        if (DPB !== 5'b00011) begin
            failures++;
            $display("[TB] FAIL simul_dpb: DPB=%b, required 00011", DPB);
        end
        PB = 5'b00000;
        r0 = t0 + 6;
        waitToEdge(r0 + 5);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL simul_dpb_fall: DPB=%b, required 00000", DPB);
        end
        waitToEdge(r0 + 8);
    endtask

    task automatic test_priority();
        int unsigned t0;
        int unsigned r0;
        t0 = cyc + 1;
        PB = 5'b10100;
        pushExp(t0 + 5, 5'b10000, 1'b1);
        pushExp(t0 + 15, 5'b00100, 1'b0);
        waitToEdge(t0 + 5);
        checks++;
        if (DPB !== 5'b10100) begin
            failures++;
            $display("[TB] FAIL prio_dpb: DPB=%b, required 10100", DPB);
        end
        waitToEdge(t0 + 15);
        PB = 5'b00000;
        r0 = t0 + 16;
        waitToEdge(r0 + 8);
        t0 = cyc + 1;
        PB = 5'b01001;
        pushExp(t0 + 5, 5'b01000, 1'b1);
        waitToEdge(t0 + 5);
        PB = 5'b00000;
        r0 = t0 + 6;
        waitToEdge(r0 + 5);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL prio_dpb_fall: DPB=%b, required 00000", DPB);
        end
        waitToEdge(r0 + 8);
    endtask

    task automatic test_release_glitch();
        int unsigned t0;
        int unsigned r0;
        t0 = cyc + 1;
        PB = 5'b01000;
        pushExp(t0 + 5, 5'b01000, 1'b0);
        pushExp(t0 + 17, 5'b01000, 1'b0);
        pushExp(t0 + 20, 5'b01000, 1'b0);
        waitToEdge(t0 + 6);
        PB = 5'b00000;
        waitToEdge(t0 + 8);
        PB = 5'b01000;
        for (int unsigned e = t0 + 9; e <= t0 + 19; e++) begin
            waitToEdge(e);
            checks++;
            if (DPB[3] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL glitch_dpb edge %0d: DPB[3]=%b, required 1", e, DPB[3]);
            end
        end
        PB = 5'b00000;
        r0 = t0 + 20;
        waitToEdge(r0 + 5);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL glitch_dpb_fall: DPB=%b, required 00000", DPB);
        end
        waitToEdge(r0 + 8);
    endtask

    task automatic test_reset_clears();
        int unsigned t0;
        t0 = cyc + 1;
        PB = 5'b00001;
        pushExp(t0 + 5, 5'b00001, 1'b0);
        waitToEdge(t0 + 6);
        checks++;
        if (DPB !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL rstclr_dpb_set: DPB=%b, required 00001", DPB);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL rstclr_dpb_async: DPB=%b, required 00000", DPB);
        end
        PB = 5'b00000;
        @(negedge Clk);
        reset_n = 1'b1;
        waitToEdge(cyc + 6);
    endtask

    task automatic test_reset_mid();
        int unsigned t0;
        int unsigned e0;
        int unsigned r0;
        t0 = cyc + 1;
        PB = 5'b00010;
        waitToEdge(t0 + 4);
        reset_n = 1'b0;
        #1;
        checks++;
        if (DPB !== 5'b00000 || Pulse !== 5'b00000 || PulseAny !== 1'b0 || Dropped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_outputs: DPB=%b Pulse=%b PulseAny=%b Dropped=%b, required all 0",
                     DPB, Pulse, PulseAny, Dropped);
        end
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        e0 = cyc + 1;
        pushExp(e0 + 5, 5'b00010, 1'b0);
        waitToEdge(e0 + 4);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL rstmid_dpb_early: DPB=%b, required 00000", DPB);
        end
        waitToEdge(e0 + 5);
        checks++;
        if (DPB !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL rstmid_dpb_rise: DPB=%b, required 00010", DPB);
        end
        waitToEdge(e0 + 6);
        PB = 5'b00000;
        r0 = e0 + 7;
        waitToEdge(r0 + 5);
        checks++;
        if (DPB !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL rstmid_dpb_fall: DPB=%b, required 00000", DPB);
        end
        waitToEdge(r0 + 8);
    endtask

    task automatic test_end();
        waitToEdge(cyc + 5);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
        end
    endtask

    // Runs every scenario in order with the scoreboard monitor alongside.
    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        PB       = 5'b00000;
        fork
            monitorLoop();
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_priority();
        test_release_glitch();
        test_reset_clears();
        test_reset_mid();
        test_end();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
